// File: rtl/gap_pkg.sv
// Shared types and elaboration helpers for the global-average-pool stage.
package gap_pkg;

  typedef enum logic {ACCUM, DRAIN} gap_state_t;

  // Rounded fixed-point reciprocal of the pixel count, with `shift` fraction bits.
  function automatic int gap_recip(input int npix, input int shift);
    return ((1 << shift) + npix / 2) / npix;
  endfunction

  function automatic longint sat_dw(input longint value, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/gap_avg_scale.sv
// Combinational average: acc * RECIP, round half-up at RECIP_SHIFT, saturate to DATA_WIDTH.
// Zero latency, no flow control.
module gap_avg_scale
  import gap_pkg::*;
#(
  parameter int ACC_W       = 14,
  parameter int DATA_WIDTH  = 8,
  parameter int RECIP       = 1337,
  parameter int RECIP_SHIFT = 16
) (
  input  logic signed [ACC_W-1:0]      acc_in,
  output logic signed [DATA_WIDTH-1:0] avg_out
);

  // Two guard bits: one for the sign of RECIP, one for the rounding add.
  localparam int PROD_W = ACC_W + RECIP_SHIFT + 2;
  localparam logic signed [PROD_W-1:0] RECIP_S = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(longint'(1) <<< (RECIP_SHIFT - 1));

  logic signed [PROD_W-1:0] acc_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rnd;

  always_comb begin
    acc_x   = PROD_W'(acc_in);
    prod    = acc_x * RECIP_S;
    rnd     = (prod + HALF) >>> RECIP_SHIFT;
    avg_out = DATA_WIDTH'(sat_dw(longint'(rnd), DATA_WIDTH));
  end

endmodule

// File: rtl/gap_stream_pool.sv
// Global average pool: sums IN_HEIGHT*IN_WIDTH pixels per channel, then drains one average per beat (out_valid the cycle after the last pixel).
// in_ready is low while draining; out_ready=0 freezes the drain. GAP_LAST_CHECK_EN adds in_last/frame_err framing checks.
module gap_stream_pool
  import gap_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int IN_HEIGHT   = 7,
  parameter int IN_WIDTH    = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 4,
  parameter int RECIP_SHIFT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(CHANNELS)-1:0]    out_ch,
  output logic                           out_last,
`ifdef GAP_LAST_CHECK_EN
  input  logic                           in_last,
  output logic                           frame_err,
`endif
  output logic                           busy
);

  localparam int NPIX  = IN_HEIGHT * IN_WIDTH;
  localparam int ACC_W = DATA_WIDTH + $clog2(NPIX);
  localparam int PIX_W = $clog2(NPIX);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int RECIP = gap_recip(NPIX, RECIP_SHIFT);

  // FRAC_BITS only labels the binary point; the datapath is scale-invariant.
  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than DATA_WIDTH");
  end

  gap_state_t              state;
  logic [PIX_W-1:0]        pix_cnt;
  logic [CH_W-1:0]         ch_cnt;
  logic signed [ACC_W-1:0] acc [CHANNELS];

  logic pix_last;
  logic ch_last;

  assign pix_last  = (pix_cnt == PIX_W'(NPIX - 1));
  assign ch_last   = (ch_cnt == CH_W'(CHANNELS - 1));
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DRAIN);
  assign out_ch    = ch_cnt;
  assign out_last  = out_valid && ch_last;
  assign busy      = (pix_cnt != '0) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      pix_cnt <= '0;
      ch_cnt  <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else if (state == ACCUM) begin
      if (in_valid) begin
        for (int c = 0; c < CHANNELS; c++)
          acc[c] <= acc[c] + ACC_W'($signed(in_data[c*DATA_WIDTH +: DATA_WIDTH]));
        if (pix_last) begin
          pix_cnt <= '0;
          ch_cnt  <= '0;
          state   <= DRAIN;
        end else begin
          pix_cnt <= pix_cnt + PIX_W'(1);
        end
      end
    end else if (out_ready) begin
      if (ch_last) begin
        for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
        ch_cnt <= '0;
        state  <= ACCUM;
      end else begin
        ch_cnt <= ch_cnt + CH_W'(1);
      end
    end
  end

`ifdef GAP_LAST_CHECK_EN
  // Sticky: in_last disagreeing with the pixel count in either direction.
  always_ff @(posedge clk) begin
    if (rst)
      frame_err <= 1'b0;
    else if (in_valid && in_ready && (in_last != pix_last))
      frame_err <= 1'b1;
  end
`endif

  gap_avg_scale #(
    .ACC_W      (ACC_W),
    .DATA_WIDTH (DATA_WIDTH),
    .RECIP      (RECIP),
    .RECIP_SHIFT(RECIP_SHIFT)
  ) u_scale (
    .acc_in (acc[ch_cnt]),
    .avg_out(out_data)
  );

endmodule

// File: tb/tb_gap_stream_pool.sv
// Directed bench for gap_stream_pool with a queue scoreboard and a negedge monitor.
module tb_gap_stream_pool;

  localparam int CH = 16;
  localparam int DW = 8;
  localparam int NP = 49;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*DW-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  out_data;
  logic [3:0]            out_ch;
  logic                  out_last;
  logic                  busy;
`ifdef GAP_LAST_CHECK_EN
  logic                  in_last;
  logic                  frame_err;
`endif

  typedef struct packed {
    logic signed [DW-1:0] d;
    logic [3:0]           ch;
    logic                 last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;

  gap_stream_pool dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_last (out_last),
`ifdef GAP_LAST_CHECK_EN
    .in_last  (in_last),
    .frame_err(frame_err),
`endif
    .busy     (busy)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_ch"},    out_ch,    0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_out_data"},  out_data,  0);
  endtask

  // Monitor: at each negedge choose out_ready, then score the beat the next posedge takes.
  initial begin
    exp_t                 e;
    logic                 stalled = 1'b0;
    logic                 prev_last_beat = 1'b0;
    logic signed [DW-1:0] hold_d = '0;
    logic [3:0]           hold_ch = '0;
    forever begin
      @(negedge clk);
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst) begin
        stalled = 1'b0;
        prev_last_beat = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data",  out_data,  hold_d);
          chk("hold_ch",    out_ch,    hold_ch);
        end
        if (prev_last_beat) begin
          chk("gap_in_ready",  in_ready,  1);
          chk("gap_out_valid", out_valid, 0);
        end
        if (out_valid) begin
          chk("drain_in_ready", in_ready, 0);
          if (out_ready) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: ch %0d data %0d with empty scoreboard", out_ch, out_data);
            end else begin
              e = q.pop_front();
              chk("out_data", out_data, e.d);
              chk("out_ch",   out_ch,   e.ch);
              chk("out_last", out_last, e.last);
            end
          end
        end
        stalled        = out_valid && !out_ready;
        hold_d         = out_data;
        hold_ch        = out_ch;
        prev_last_beat = out_valid && out_ready && out_last;
      end
    end
  end

  task automatic push_pixel(input logic [CH*DW-1:0] d, input logic lst);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
`ifdef GAP_LAST_CHECK_EN
    in_last  = lst;
`else
    if (lst === 1'bx) in_data = d;
`endif
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
    end
    @(negedge clk);
  endtask

  // mode 0: every lane = val, average expv; mode 1: lane c = c-8.
  task automatic send_frame(input int mode, input int val, input int expv, input bit toggle,
                            input int first, input int cnt, input int bad, input bit exp_en);
    logic [CH*DW-1:0] d;
    for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'(mode == 1 ? c - 8 : val);
    if (exp_en)
      for (int c = 0; c < CH; c++)
        q.push_back(exp_t'{d: DW'(mode == 1 ? c - 8 : expv), ch: 4'(c), last: (c == CH - 1)});
    for (int p = first; p < first + cnt; p++) begin
      push_pixel(d, (p == NP - 1) || (p == bad));
      if (toggle) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d averages still expected after 500 cycles", q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef GAP_LAST_CHECK_EN
    in_last   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Unity, negative full scale, positive full scale.
    send_frame(0, 16, 16, 1'b0, 0, NP, -1, 1'b1);
    wait_idle();
    send_frame(0, -128, -128, 1'b0, 0, NP, -1, 1'b1);
    wait_idle();
    send_frame(0, 127, 127, 1'b0, 0, NP, -1, 1'b1);
    wait_idle();

    // Per-lane ramp with input bubbles and random output stalls.
    rand_rdy = 1'b1;
    send_frame(1, 0, 0, 1'b1, 0, NP, -1, 1'b1);
    wait_idle();
    rand_rdy = 1'b0;
    @(negedge clk);

    // Back-to-back frames: B waits through A's drain.
    send_frame(0, 1, 1, 1'b0, 0, NP, -1, 1'b1);
    send_frame(0, -1, -1, 1'b0, 0, NP, -1, 1'b1);
    wait_idle();

    // Partial frame discarded by reset.
    send_frame(0, 5, 5, 1'b0, 0, 20, -1, 1'b0);
    chk("partial_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midframe_reset");
    send_frame(0, 32, 32, 1'b0, 0, NP, -1, 1'b1);
    wait_idle();

`ifdef GAP_LAST_CHECK_EN
    chk("frame_err_clean", frame_err, 0);
    send_frame(0, 2, 2, 1'b0, 0, 30, 29, 1'b1);
    chk("frame_err_set", frame_err, 1);
    chk("early_last_no_drain", out_valid, 0);
    send_frame(0, 2, 2, 1'b0, 30, NP - 30, -1, 1'b0);
    wait_idle();
    chk("frame_err_sticky", frame_err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
